// File: rtl/disp_wr_ctrl.sv
// disp_wr_ctrl: write-side controller for the display cell memory.
// Buffers single-cell updates in a small FIFO and issues at most one write
// per disp_clk cycle. A hardware clear sequencer sweeps all 128 cells with
// a fill colour.
// Optional feature macro: DISP_WR_VBLANK_EN. When defined, writes are only
// issued while i_sync_va is low (vertical blanking).
`timescale 1ns/1ps

module disp_wr_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       disp_clk,
   input  logic       rst_disp,
   input  logic       i_upd_valid,
   output logic       o_upd_ready,
   input  logic [6:0] i_upd_adr,
   input  logic [3:0] i_upd_d,
   input  logic       i_clr_req,
   input  logic [3:0] i_clr_d,
   output logic       o_clr_busy,
   input  logic       i_sync_va,
   output logic       o_disp_wen,
   output logic       o_disp_men,
   output logic [6:0] o_disp_adr,
   output logic [3:0] o_disp_d
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   logic [10:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [6:0]       sweep_cnt;
   logic [3:0]       fill;

   logic eligible;
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic clr_accept;
   logic sweep_wr;
   logic sweep_last;

   assign full        = (count == DEPTH_C);
   assign empty       = (count == '0);
   assign o_upd_ready = ~full;
   assign push        = i_upd_valid & ~full;
   assign sweep_last  = sweep_wr & (sweep_cnt == 7'd127);

`ifdef DISP_WR_VBLANK_EN
   assign eligible = ~i_sync_va;
`else
   logic sync_va_unused;
   assign sync_va_unused = i_sync_va;
   assign eligible       = 1'b1;
`endif

   // State register
   always_ff @(posedge disp_clk) begin
      if (rst_disp) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: a clear request wins in IDLE, the sweep ends after cell 127
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (i_clr_req) state_next = CLEAR;
         CLEAR:   if (sweep_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Per-state actions: accept clear / pop FIFO in IDLE, sweep write in CLEAR
   always_comb begin
      clr_accept = 1'b0;
      pop        = 1'b0;
      sweep_wr   = 1'b0;
      unique case (state)
         IDLE: begin
            clr_accept = i_clr_req;
            pop        = ~i_clr_req & eligible & ~empty;
         end
         CLEAR:   sweep_wr = eligible;
         default: ;
      endcase
   end

   // FIFO storage; a push on the clear-accept edge is still written and kept
   always_ff @(posedge disp_clk) begin
      if (push) begin
         mem[wr_ptr] <= {i_upd_adr, i_upd_d};
      end
   end

   // FIFO pointers and count; accepting a clear drops everything queued before it
   always_ff @(posedge disp_clk) begin
      if (rst_disp) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (clr_accept) begin
            rd_ptr <= wr_ptr;
            count  <= push ? CNT_W'(1) : '0;
         end else begin
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Sweep counter and captured fill colour; counter stops at 127 instead of wrapping
   always_ff @(posedge disp_clk) begin
      if (rst_disp) begin
         sweep_cnt <= '0;
         fill      <= '0;
      end else if (clr_accept) begin
         sweep_cnt <= '0;
         fill      <= i_clr_d;
      end else if (sweep_wr && !sweep_last) begin
         sweep_cnt <= sweep_cnt + 7'd1;
      end
   end

   // Registered write port; address/data hold between writes
   always_ff @(posedge disp_clk) begin
      if (rst_disp) begin
         o_disp_wen <= 1'b0;
         o_disp_men <= 1'b0;
         o_disp_adr <= '0;
         o_disp_d   <= '0;
         o_clr_busy <= 1'b0;
      end else begin
         o_disp_wen <= sweep_wr | pop;
         o_disp_men <= sweep_wr | pop;
         if (sweep_wr) begin
            o_disp_adr <= sweep_cnt;
            o_disp_d   <= fill;
         end else if (pop) begin
            {o_disp_adr, o_disp_d} <= mem[rd_ptr];
         end
         o_clr_busy <= (state_next == CLEAR);
      end
   end

endmodule

// File: doc/disp_wr_ctrl.md
# disp_wr_ctrl

Write-side controller that feeds the display's cell-memory write port (`disp_wen`/`disp_men`/`disp_adr`/`disp_d`) from game logic. It buffers single-cell updates in a small FIFO and issues at most one write per clock. It also runs a hardware clear sequencer that sweeps all 128 cells with a fill colour. It sits directly upstream of the display block, in the `disp_clk` domain.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: update FIFO depth; power of two, ≥2.

Ports:
- `disp_clk` in 1: display clock; all logic is on its rising edge.
- `rst_disp` in 1: synchronous, active-high reset.
- `i_upd_valid` in 1: a cell update is offered.
- `o_upd_ready` out 1: the FIFO can accept; equals FIFO not full.
- `i_upd_adr` in 7: cell address, 0..127.
- `i_upd_d` in 4: cell colour code.
- `i_clr_req` in 1: clear request, level-sampled.
- `i_clr_d` in 4: fill colour, captured when a clear is accepted.
- `o_clr_busy` out 1: a clear sweep is in progress.
- `i_sync_va` in 1: vertical-active from the sync generator; used only with `DISP_WR_VBLANK_EN`.
- `o_disp_wen` out 1: write strobe to the display.
- `o_disp_men` out 1: memory enable; identical to `o_disp_wen`.
- `o_disp_adr` out 7: write address.
- `o_disp_d` out 4: write data.

## Operation
- Push: an update is pushed when `i_upd_valid && o_upd_ready`. `o_upd_ready` is registered-state derived and depends only on the FIFO count, never on `i_upd_valid`.
- States:
  - IDLE: drain the FIFO.
  - CLEAR: sweep a 7-bit counter from 0 to 127.
- IDLE → CLEAR when `i_clr_req=1`. The same edge captures `i_clr_d` and zeroes the counter.
  - Entries already in the FIFO at that edge are discarded as stale.
  - An update pushed on that same edge is kept, because it logically follows the clear.
- In CLEAR, each eligible cycle issues a write of (counter, fill) and increments the counter. After the write to 127 the state returns to IDLE. The counter never wraps.
- During CLEAR the FIFO still accepts pushes up to full but is not drained. Draining resumes in IDLE.
- `i_clr_req` is ignored while in CLEAR. It has priority over a pending FIFO pop in IDLE: that cycle pops nothing.
- Eligible cycle: every cycle when the macro is off. See Configuration for the macro-on case.
- In IDLE, each eligible cycle with the FIFO non-empty pops one entry and issues it as a write.
- Non-eligible cycles issue nothing, and the FIFO and counter hold.
- All outputs are registered. `o_disp_wen`/`o_disp_men` are one-cycle pulses per write; they are low on any cycle with no write.
- `o_disp_adr`/`o_disp_d` hold their last values when no write is issued.

## Timing
- Reset values:
  - `o_disp_wen`, `o_disp_men`, `o_disp_adr`, `o_disp_d`, `o_clr_busy`: 0.
  - `o_upd_ready`: 1.
  - FIFO: empty; state: IDLE.
- Update latency: a push accepted at edge N with the FIFO otherwise empty produces `o_disp_wen=1` from edge N+1 for exactly one cycle.
- Throughput: one write per cycle sustained.
- Full FIFO: `o_upd_ready=0`, and no push occurs even if a pop happens the same cycle. Ready returns at the edge after the pop.
- Clear accepted at edge N with no stalls:
  - `o_clr_busy=1` from edge N.
  - Writes to adr 0..127 are presented from edges N+1..N+128.
  - `o_clr_busy=0` from edge N+128, coincident with the adr 127 write.
  - The first FIFO write can appear at N+129.
- Stalls extend the sweep cycle-for-cycle.
- Reset mid-clear or with a non-empty FIFO: at the next edge everything returns to reset values and no further writes are issued.

## Configuration
- `DISP_WR_VBLANK_EN` defined: a cycle is eligible only when `i_sync_va=0`, so writes land only in vertical blanking (tear-free).
- Undefined: `i_sync_va` is ignored and every cycle is eligible.

## Test plan
- Reset with `i_upd_valid=1`: all outputs at reset values; no write for the duration of reset.
- Push (adr 5, d 3) at edge N into an empty FIFO → `o_disp_wen=o_disp_men=1`, `adr=5`, `d=3` from edge N+1 for one cycle only.
- Push 5 updates back-to-back with `FIFO_DEPTH=4` and drain blocked by a clear → `o_upd_ready=0` after 4; the 5th is held by the source and accepted once drain resumes. All 5 appear in order.
- Clear with `i_clr_d=7` while 2 entries are queued → 128 writes, adr 0..127 all d=7. The 2 queued entries are never written. `o_clr_busy` is high 128 cycles.
- `i_clr_req` held high through a sweep → exactly one sweep; a second sweep starts only if the request is still high in IDLE.
- With `DISP_WR_VBLANK_EN` defined, `i_sync_va=1` for 10 cycles with 3 queued → no writes. After `i_sync_va` falls, the 3 writes occur on consecutive cycles.
